// File: rtl/burst_pkg.sv
// Shared types and sizing helpers for the burst SRAM slave.
// Default-configuration widths are provided alongside the helpers.
package burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_RESP
  } state_t;

  localparam int NUM_WORDS_DEF = 128;
  localparam int RD_LEN_DEF    = 8;
  localparam int WR_LEN_DEF    = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int beat_w(input int rl, input int wl);
    return $clog2(max2(rl, wl) + 1);
  endfunction

  localparam int IDX_W  = $clog2(NUM_WORDS_DEF);
  localparam int BEAT_W = beat_w(RD_LEN_DEF, WR_LEN_DEF);

endpackage

// File: rtl/sram_word_array.sv
// Word-organised storage: asynchronous read port and a
// byte-strobed synchronous write port. Contents are not reset.
module sram_word_array #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 128,
  localparam int IW = $clog2(NUM_WORDS),
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic [IW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_q,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]         wr_strb
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  assign rd_q = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/burst_sram_slave.sv
// Burst memory slave: one request at a time, then a fixed-length
// read stream or write absorption over valid/ready channels.
module burst_sram_slave
  import burst_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int NUM_WORDS       = 128,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [DATA_ADDR_WIDTH-1:0] req_addr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_last,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [DATA_WIDTH/8-1:0]    wr_strb,
  input  logic                       wr_last,
  output logic                       wr_done,
  output logic                       proto_err
);

  localparam int IW = $clog2(NUM_WORDS);
  localparam int BW = beat_w(READ_BURST_LEN, WRITE_BURST_LEN);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [BW-1:0] RD_END  = BW'(READ_BURST_LEN - 1);
  localparam logic [BW-1:0] WR_END  = BW'(WRITE_BURST_LEN - 1);
  localparam logic [LW-1:0] LAT_END = LW'(READ_LATENCY - 1);

  state_t state, state_nx;

  logic [IW-1:0]         idx;
  logic [IW-1:0]         rd_addr;
  logic [BW-1:0]         cnt;
  logic [LW-1:0]         lat;
  logic [DATA_WIDTH-1:0] q;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  unused_addr;

  assign req_fire = req_valid & req_ready;
  assign rd_fire  = rd_valid & rd_ready;
  assign wr_fire  = wr_valid & wr_ready;

  assign unused_addr = ^{req_addr[1:0],
                         req_addr[DATA_ADDR_WIDTH-1:IW+2]};

  sram_word_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_array (
    .clk     (cpu_clk),
    .rd_addr (rd_addr),
    .rd_q    (q),
    .wr_en   (wr_fire),
    .wr_addr (idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // While streaming, look one word ahead so rd_data reloads on handshake.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rd_valid  = 1'b0;
    wr_ready  = 1'b0;
    wr_done   = 1'b0;
    rd_addr   = idx;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx = req_write ? WR_BURST : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat == LAT_END) state_nx = RD_BURST;
      end
      RD_BURST: begin
        rd_valid = 1'b1;
        rd_addr  = idx + 1'b1;
        if (rd_ready && cnt == RD_END) state_nx = IDLE;
      end
      WR_BURST: begin
        wr_ready = 1'b1;
        if (wr_valid && cnt == WR_END) state_nx = WR_RESP;
      end
      WR_RESP: begin
        wr_done  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      idx       <= '0;
      cnt       <= '0;
      lat       <= '0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (req_fire) begin
        idx <= req_addr[2 +: IW];
        cnt <= '0;
        lat <= '0;
      end
      if (state == RD_WAIT) begin
        lat <= lat + 1'b1;
        if (lat == LAT_END) begin
          rd_data <= q;
          rd_last <= (RD_END == '0);
        end
      end
      if (rd_fire) begin
        idx     <= idx + 1'b1;
        cnt     <= cnt + 1'b1;
        rd_data <= q;
        rd_last <= (cnt + 1'b1 == RD_END);
      end
      if (wr_fire) begin
        idx <= idx + 1'b1;
        cnt <= cnt + 1'b1;
        if (wr_last != (cnt == WR_END)) proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_burst_sram_slave.sv
// Directed bench for burst_sram_slave: reset, read/write bursts,
// wrap-around, stalls, byte strobes, wr_last errors, mid-burst reset.
module tb_burst_sram_slave;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NW  = 128;
  localparam int RL  = 8;
  localparam int WL  = 8;
  localparam int LAT = 2;

  logic          cpu_clk   = 1'b0;
  logic          cpu_rst   = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic          rd_valid;
  logic          rd_ready  = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          wr_valid  = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data   = '0;
  logic [3:0]    wr_strb   = '0;
  logic          wr_last   = 1'b0;
  logic          wr_done;
  logic          proto_err;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] model [NW];
  logic          exp_perr = 1'b0;

  always #5 cpu_clk = ~cpu_clk;

  burst_sram_slave #(
    .DATA_WIDTH      (DW),
    .DATA_ADDR_WIDTH (AW),
    .NUM_WORDS       (NW),
    .READ_BURST_LEN  (RL),
    .WRITE_BURST_LEN (WL),
    .READ_LATENCY    (LAT)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_last   (wr_last),
    .wr_done   (wr_done),
    .proto_err (proto_err)
  );

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({req_ready, rd_valid, rd_last, wr_ready, wr_done, proto_err}
        !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 100000",
               {req_ready, rd_valid, rd_last, wr_ready, wr_done, proto_err});
    end
    n_cmp++;
    if (rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rd_data got %h want 0", rd_data);
    end
    cpu_rst = 1'b0;
    step();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic write_burst(input int word, input logic [31:0] base,
                             input logic [31:0] stp, input logic [3:0] strb,
                             input int last_beat, input string tag);
    logic [31:0] d;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = word * 4;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s req_ready got %b want 1", tag, req_ready);
    end
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
    for (int b = 0; b < WL; b++) begin
      d        = base + b * stp;
      wr_valid = 1'b1;
      wr_data  = d;
      wr_strb  = strb;
      wr_last  = (b == last_beat);
      n_cmp++;
      if (wr_ready !== 1'b1 || wr_done !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s beat%0d wr_ready/wr_done/req_ready got %b%b%b want 100",
                 tag, b, wr_ready, wr_done, req_ready);
      end
      step();
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) model[(word + b) % NW][8*k +: 8] = d[8*k +: 8];
      end
      if ((b == last_beat) != (b == WL - 1)) exp_perr = 1'b1;
      n_cmp++;
      if (proto_err !== exp_perr) begin
        n_bad++;
        $display("FAIL %s beat%0d proto_err got %b want %b",
                 tag, b, proto_err, exp_perr);
      end
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    n_cmp++;
    if (wr_done !== 1'b1 || wr_ready !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s wr_done/wr_ready/req_ready got %b%b%b want 100",
               tag, wr_done, wr_ready, req_ready);
    end
    step();
    n_cmp++;
    if (wr_done !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s post wr_done/req_ready got %b%b want 01",
               tag, wr_done, req_ready);
    end
  endtask

  task automatic read_burst(input int word, input int stall,
                            input logic hold_req, input string tag);
    logic [31:0] e;
    int          ns;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = word * 4;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s req_ready got %b want 1", tag, req_ready);
    end
    step();
    req_valid = hold_req;
    req_write = hold_req;
    for (int i = 0; i < LAT; i++) begin
      n_cmp++;
      if (rd_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s wait%0d rd_valid/req_ready got %b%b want 00",
                 tag, i, rd_valid, req_ready);
      end
      step();
    end
    for (int b = 0; b < RL; b++) begin
      e  = model[(word + b) % NW];
      ns = (b % 2 == 1) ? stall : 0;
      for (int s = 0; s <= ns; s++) begin
        rd_ready = (s == ns);
        if (s == ns && b == RL - 1) req_valid = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== e ||
            rd_last !== (b == RL - 1) || req_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL %s beat%0d.%0d v/data/last/rq got %b %h %b %b want 1 %h %b 0",
                   tag, b, s, rd_valid, rd_data, rd_last, req_ready,
                   e, (b == RL - 1));
        end
        step();
      end
    end
    rd_ready  = 1'b0;
    req_write = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s end v/last/rq got %b%b%b want 001",
               tag, rd_valid, rd_last, req_ready);
    end
    n_cmp++;
    if (proto_err !== exp_perr) begin
      n_bad++;
      $display("FAIL %s proto_err got %b want %b", tag, proto_err, exp_perr);
    end
  endtask

  task automatic test_preload();
    for (int w = 0; w < NW / WL; w++) begin
      write_burst(w * WL, w * WL, 1, 4'hF, WL - 1, "preload");
    end
  endtask

  task automatic test_read_basic();
    read_burst(4, 0, 1'b0, "rd_basic");
  endtask

  task automatic test_read_wrap();
    read_burst(126, 0, 1'b0, "rd_wrap");
  endtask

  task automatic test_read_stall();
    read_burst(40, 2, 1'b1, "rd_stall");
  endtask

  task automatic test_write_full();
    write_burst(16, 32'hA0, 1, 4'hF, WL - 1, "wr_a0");
    read_burst(16, 0, 1'b0, "rd_a0");
  endtask

  task automatic test_write_strb();
    write_burst(16, 32'hDEADBEEF, 0, 4'hF, WL - 1, "wr_dead");
    write_burst(16, 32'h12345678, 0, 4'h1, 3, "wr_strb");
    read_burst(16, 1, 1'b0, "rd_strb");
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    step();
    req_valid = 1'b0;
    repeat (LAT) step();
    rd_ready = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== model[7]) begin
      n_bad++;
      $display("FAIL rst_mid beat3 v/data got %b %h want 1 %h",
               rd_valid, rd_data, model[7]);
    end
    cpu_rst = 1'b1;
    #1;
    exp_perr = 1'b0;
    n_cmp++;
    if ({req_ready, rd_valid, rd_last, wr_ready, wr_done, proto_err}
        !== 6'b100000 || rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid flags/data got %b %h want 100000 0",
               {req_ready, rd_valid, rd_last, wr_ready, wr_done, proto_err},
               rd_data);
    end
    rd_ready = 1'b0;
    step();
    cpu_rst = 1'b0;
    step();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid release req_ready got %b want 1", req_ready);
    end
    read_burst(4, 0, 1'b0, "rd_after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload();
    test_read_basic();
    test_read_wrap();
    test_read_stall();
    test_write_full();
    test_write_strb();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_sram_slave.md
# burst_sram_slave

Single-clock burst memory slave that serves the chip's instruction and data fills and writebacks. It accepts one burst request at a time, then streams READ_BURST_LEN words out or absorbs WRITE_BURST_LEN words in over valid/ready channels. It sits directly below the chip's memory port in the top-level bench and is instantiated once per memory (inst and data).

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DATA_ADDR_WIDTH, 32, byte-address width of req_addr.
- NUM_WORDS, 128, array depth; power of two.
- READ_BURST_LEN, 8, beats per read burst; ≥1.
- WRITE_BURST_LEN, 8, beats per write burst; ≥1.
- READ_LATENCY, 2, cycles from request acceptance to first rd_valid; ≥1.
- cpu_clk  in  1  sole clock, rising edge.
- cpu_rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  burst request present.
- req_ready  out  1  slave idle, can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  DATA_ADDR_WIDTH  byte start address.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  master accepts read beat.
- rd_data  out  DATA_WIDTH  read beat.
- rd_last  out  1  final read beat.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  slave accepts write beat.
- wr_data  in  DATA_WIDTH  write beat.
- wr_strb  in  DATA_WIDTH/8  byte enables.
- wr_last  in  1  master marks final write beat.
- wr_done  out  1  one-cycle pulse, write burst complete.
- proto_err  out  1  sticky wr_last mismatch flag.

## Operation
- States: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_RESP.
- IDLE: req_ready=1. On req_valid&req_ready latch word index = req_addr[2 +: log2(NUM_WORDS)] (low 2 bits and bits above index ignored, aliasing allowed), clear beat counter; go RD_WAIT (read) or WR_BURST (write).
- RD_WAIT: count READ_LATENCY-1 cycles, then RD_BURST with first word loaded.
- RD_BURST: rd_valid=1; rd_data/rd_last held stable while rd_ready=0. On rd_valid&rd_ready advance index and counter; rd_last=1 exactly on beat READ_BURST_LEN-1; after it go IDLE.
- WR_BURST: wr_ready=1. Each wr_valid&wr_ready writes bytes with wr_strb=1 at current index, then advances. After beat WRITE_BURST_LEN-1 go WR_RESP.
- WR_RESP: wr_done=1 for one cycle, then IDLE.
- Index increments modulo NUM_WORDS: burst starting at word NUM_WORDS-2 reads/writes words NUM_WORDS-2, NUM_WORDS-1, 0, 1, ...
- proto_err set when wr_last disagrees with (counter==WRITE_BURST_LEN-1) on an accepted beat; burst still completes by count. Cleared only by reset.
- Reads return data of writes completed in earlier bursts.

## Timing
- Reset: state IDLE, req_ready=1, rd_valid=0, rd_last=0, rd_data=0, wr_ready=0, wr_done=0, proto_err=0. Array contents not reset.
- Request accepted at edge T → first rd_valid visible after edge T+READ_LATENCY.
- Zero-stall read burst: READ_BURST_LEN consecutive rd_valid cycles; IDLE (req_ready=1) the cycle after the last handshake.
- Write burst: wr_ready=1 from the cycle after acceptance; wr_done one cycle after final beat; req_ready one cycle after wr_done.
- No request is accepted while a burst or WR_RESP is in progress; req_valid ignored there.
- rd_valid never drops without a handshake once raised.
- Reset mid-burst: burst abandoned immediately, beats already written persist, outputs return to reset values.

## Structure
- Package burst_pkg: state enum, IDX_W = $clog2(NUM_WORDS), BEAT_W = $clog2(max(READ_BURST_LEN, WRITE_BURST_LEN)+1).
- Sub-module sram_word_array: NUM_WORDS×DATA_WIDTH, one read port, one byte-strobed write port. Instance name u_array, storage named mem so benches preload via $readmemh.

## Test plan
- Preload mem[i]=i; read req_addr=0x10, rd_ready=1 → rd_valid first at T+2, data 4..11, rd_last on 11, req_ready back next cycle.
- Read req_addr=0x1F8 (word 126), NUM_WORDS=128 → data 126,127,0,1,...,5.
- Read with rd_ready toggling 1,0,0,1... → each beat held stable across stalls, 8 beats total, order unchanged.
- Write req_addr=0x40, data 0xA0..0xA7, wr_strb=0xF, wr_last on beat 7 → wr_done pulse one cycle later, proto_err=0; read back returns 0xA0..0xA7.
- Write with wr_strb=0x1 on word 16 holding 0xDEADBEEF, wr_data=0x12345678 → word reads 0xDEADBE78; wr_last on beat 3 → proto_err=1 and stays 1.
- Assert cpu_rst at beat 3 of read burst → rd_valid=0 same cycle, req_ready=1 after release, next read correct.
